// File: rtl/audio_system_pio_pkg.sv
// Shared register map and defaults for the audio system LED PIO.
package audio_system_pio_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int BUS_W         = 32;

    typedef logic [2:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA   = 3'd0;
    localparam pio_addr_t ADDR_BLINK  = 3'd1;
    localparam pio_addr_t ADDR_STATUS = 3'd3;
    localparam pio_addr_t ADDR_OUTSET = 3'd4;
    localparam pio_addr_t ADDR_OUTCLR = 3'd5;

endpackage

// File: rtl/audio_system_pio_leds_if.sv
// Avalon-MM slave bus of the LED PIO: word address, select, write strobe, data.
interface audio_system_pio_leds_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/audio_system_pio_blink_timer.sv
// Free-running blink prescaler: counts 0..BLINK_DIV-1 and toggles phase on each wrap.
module audio_system_pio_blink_timer #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic phase
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            phase   <= 1'b0;
        end else if (count_q == TERM_CNT) begin
            count_q <= '0;
            phase   <= ~phase;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audio_system_pio_leds.sv
// LED PIO with data/outset/outclear registers and optional per-bit blinking.
// Blinking (blink_mask register and prescaler) is built only when AUDIO_SYSTEM_PIO_LEDS_BLINK_EN is defined.
module audio_system_pio_leds
    import audio_system_pio_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          BLINK_DIV   = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    audio_system_pio_leds_if.slave bus,
    output logic [WIDTH-1:0]       out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] out_val;
    logic [31:0]      rd_mux;

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    // Upper write-data bits are architecturally ignored.
    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = |bus.writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   data_q <= wdata;
                ADDR_OUTSET: data_q <= data_q | wdata;
                ADDR_OUTCLR: data_q <= data_q & ~wdata;
                default:     data_q <= data_q;
            endcase
        end
    end

`ifdef AUDIO_SYSTEM_PIO_LEDS_BLINK_EN
    logic phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_en && (bus.address == ADDR_BLINK)) begin
            mask_q <= wdata;
        end
    end

    audio_system_pio_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .phase   (phase)
    );

    // Masked bits follow data while phase is low and are inverted while it is high.
    assign out_val = data_q ^ (mask_q & {WIDTH{phase}});
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign mask_q  = '0;
    assign out_val = data_q;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux = 32'(data_q);
            ADDR_BLINK:  rd_mux = 32'(mask_q);
            ADDR_STATUS: rd_mux = 32'(out_val);
            default:     rd_mux = '0;
        endcase
    end

    // Read data is reloaded every edge regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign out_port = out_val;

endmodule

// File: tb/tb_audio_system_pio_leds.sv
// Directed self-checking bench for audio_system_pio_leds (WIDTH=10, BLINK_DIV=4).
module tb_audio_system_pio_leds;
    import audio_system_pio_pkg::*;

    localparam int WIDTH     = 10;
    localparam int BLINK_DIV = 4;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] out_port;
    int               n_checks = 0;
    int               n_errors = 0;

    audio_system_pio_leds_if bus ();

    audio_system_pio_leds #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (32'd0),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    // LED pattern k edges after reset release with data=0 and blink_mask=0x003.
    function automatic logic [31:0] blink_exp(input int k);
        return (((k / BLINK_DIV) % 2) == 1) ? 32'h003 : 32'h000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        #3 reset_n = 1'b0;
        #1 chk("rst_async_out", 32'(out_port), 32'h000);
        tick;
        tick;
        chk("rst_out", 32'(out_port), 32'h000);
        chk("rst_rdata", bus.readdata, 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            chk($sformatf("rst_read_a%0d", a), rd, 32'h0);
        end
        chk("idle_out", 32'(out_port), 32'h000);

        bus_write(ADDR_DATA, 32'h155);
        chk("wr_data_out", 32'(out_port), 32'h155);
        bus_read(ADDR_DATA, rd);
        chk("rd_data", rd, 32'h155);
        bus_read(ADDR_STATUS, rd);
        chk("rd_status", rd, 32'h155);

        bus_write(ADDR_OUTSET, 32'h00A);
        chk("outset_out", 32'(out_port), 32'h15F);
        bus_write(ADDR_OUTCLR, 32'h101);
        chk("outclr_out", 32'(out_port), 32'h05E);
        bus_read(ADDR_DATA, rd);
        chk("rd_after_setclr", rd, 32'h05E);

        bus_write(ADDR_STATUS, 32'h3FF);
        chk("wr_status_ignored", 32'(out_port), 32'h05E);
        bus_write(3'd2, 32'h3FF);
        chk("wr_a2_ignored", 32'(out_port), 32'h05E);
        bus_write(3'd6, 32'h3FF);
        chk("wr_a6_ignored", 32'(out_port), 32'h05E);
        bus_write(3'd7, 32'h3FF);
        chk("wr_a7_ignored", 32'(out_port), 32'h05E);
        bus_read(ADDR_OUTSET, rd);
        chk("rd_outset_zero", rd, 32'h0);
        bus_read(ADDR_OUTCLR, rd);
        chk("rd_outclr_zero", rd, 32'h0);
        chk("rd_wo_no_effect", 32'(out_port), 32'h05E);

        bus_write(ADDR_DATA, 32'hFFFF_FEA5);
        chk("wide_wr_out", 32'(out_port), 32'h2A5);
        bus_read(ADDR_DATA, rd);
        chk("wide_wr_zext", rd, 32'h0000_02A5);

`ifdef AUDIO_SYSTEM_PIO_LEDS_BLINK_EN
        bus_write(ADDR_BLINK, 32'hFFFF_FC00);
        chk("mask_hi_out", 32'(out_port), 32'h2A5);
        bus_read(ADDR_BLINK, rd);
        chk("mask_hi_zext", rd, 32'h0);

        // Realign the prescaler so blink edges are known.
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        bus_write(ADDR_BLINK, 32'h003);
        chk("blink_k1", 32'(out_port), blink_exp(1));
        bus.address = ADDR_STATUS;
        for (int k = 2; k <= 12; k++) begin
            tick;
            chk($sformatf("blink_out_k%0d", k), 32'(out_port), blink_exp(k));
            chk($sformatf("blink_status_k%0d", k), bus.readdata, blink_exp(k - 1));
        end
        bus_read(ADDR_DATA, rd);
        chk("blink_data_stays", rd, 32'h000);
        bus_read(ADDR_BLINK, rd);
        chk("blink_mask_rd", rd, 32'h003);
        bus_write(ADDR_DATA, 32'h0F0);
        chk("blink_k15", 32'(out_port), 32'h0F3);
        for (int k = 16; k <= 19; k++) begin
            tick;
            chk($sformatf("blink_out_k%0d", k), 32'(out_port), 32'h0F0);
        end
        // Clear the mask on the edge where phase rises.
        bus_write(ADDR_BLINK, 32'h000);
        chk("mask_clr_on_toggle", 32'(out_port), 32'h0F0);
        for (int k = 21; k <= 25; k++) begin
            tick;
            chk($sformatf("no_residual_k%0d", k), 32'(out_port), 32'h0F0);
        end

        bus_write(ADDR_BLINK, 32'h3FF);
        chk("mask_full_phase0", 32'(out_port), 32'h0F0);
        bus_write(ADDR_DATA, 32'h3FF);
        chk("pre_rst_out", 32'(out_port), 32'h3FF);
        chk("pre_rst_rdata", bus.readdata, 32'h0F0);
        reset_n = 1'b0;
        #1;
        chk("mid_blink_rst_out", 32'(out_port), 32'h000);
        chk("mid_blink_rst_rdata", bus.readdata, 32'h0);
        tick;
        tick;
        reset_n = 1'b1;
        bus_read(ADDR_BLINK, rd);
        chk("rst_mask_clear", rd, 32'h0);
        bus_write(ADDR_BLINK, 32'h3FF);
        chk("post_rst_k2", 32'(out_port), 32'h000);
        tick;
        chk("post_rst_k3", 32'(out_port), 32'h000);
        tick;
        chk("post_rst_k4", 32'(out_port), 32'h3FF);
        for (int k = 5; k <= 8; k++) begin
            tick;
            chk($sformatf("post_rst_k%0d", k), 32'(out_port), (k < 8) ? 32'h3FF : 32'h000);
        end
`else
        bus_write(ADDR_BLINK, 32'h3FF);
        chk("noblink_wr_out", 32'(out_port), 32'h2A5);
        bus_read(ADDR_BLINK, rd);
        chk("noblink_rd_mask", rd, 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk($sformatf("noblink_steady_%0d", k), 32'(out_port), 32'h2A5);
        end
        bus_write(ADDR_DATA, 32'h3FF);
        bus_read(ADDR_DATA, rd);
        chk("pre_rst_rd", rd, 32'h3FF);
        reset_n = 1'b0;
        #1;
        chk("rst_out_now", 32'(out_port), 32'h000);
        chk("rst_rdata_now", bus.readdata, 32'h0);
        tick;
        reset_n = 1'b1;
        bus_read(ADDR_DATA, rd);
        chk("post_rst_rd", rd, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_system_pio_leds.md
AUDIO_SYSTEM_PIO_LEDS -- requirements
Module: audio_system_pio_leds

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning number of output bits (LEDR[9:0]).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning data register value after reset.
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, meaning clocks per blink half-period (0.5 s at 50 MHz), legal range >= 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data, bits [WIDTH-1:0] used.
REQ-010 readdata  output  32  registered read data, bits above WIDTH zero.
REQ-011 out_port  output  WIDTH  LED drive.

Function
REQ-012 Write occurs on the clk edge where chipselect=1 and write_n=0; zero wait states; at most one write per cycle.
REQ-013 Register map: addr 0 data (RW); addr 1 blink_mask (RW); addr 3 out_status (RO, current out_port); addr 4 outset (WO, data |= wd); addr 5 outclear (WO, data &= ~wd); addr 2, 6, 7 read 0, writes ignored.
REQ-014 Writes to out_status, and reads of outset/outclear (which return 0), SHALL have no side effect.
REQ-015 readdata SHALL be loaded every clk edge from the address mux, independent of chipselect: one-cycle read latency.
REQ-016 Prescaler SHALL count 0..BLINK_DIV-1 and wrap; on wrap the phase bit toggles; counter free-runs and is not restarted by register writes.
REQ-017 out_port = data ^ (blink_mask & {WIDTH{phase}}), combinational from registers only; a write becomes visible on out_port in the cycle after its edge.
REQ-018 A write coinciding with a phase toggle SHALL apply both; out_port next cycle uses the new data/mask and the new phase.
REQ-019 Clearing a blink_mask bit SHALL immediately return that out_port bit to its data value regardless of phase.
REQ-020 writedata bits above WIDTH SHALL be ignored; readback of data and blink_mask SHALL zero-extend.

Reset
REQ-021 reset_n low SHALL asynchronously set data=RESET_VALUE, blink_mask=0, prescaler=0, phase=0, readdata=0; out_port therefore equals RESET_VALUE.
REQ-022 Reset asserted mid-blink SHALL abandon the current half-period; after release the first toggle occurs BLINK_DIV cycles later.

Configuration
REQ-023 Macro AUDIO_SYSTEM_PIO_LEDS_BLINK_EN defined: blink_mask, prescaler and phase SHALL be implemented per REQ-016..019.
REQ-024 Macro undefined: no prescaler or blink_mask logic; addr 1 reads 0, writes ignored; out_port = data.

Structure
REQ-025 Register address constants (ADDR_DATA, ADDR_BLINK, ADDR_STATUS, ADDR_OUTSET, ADDR_OUTCLR) and the default WIDTH SHALL live in shared package audio_system_pio_pkg.
REQ-026 Prescaler and phase SHALL be one sub-module, audio_system_pio_blink_timer (ports clk, reset_n, phase), instantiated only under AUDIO_SYSTEM_PIO_LEDS_BLINK_EN.

Verification (WIDTH=10, BLINK_DIV=4)
REQ-027 Reset released, no access -> out_port=0x000, readdata=0 at all addresses.
REQ-028 Write 0x155 to addr 0, then read addr 0 -> readdata=0x155 one cycle after the address is presented; out_port=0x155 the cycle after the write.
REQ-029 data=0x155, write outset 0x00A then outclear 0x101 -> out_port 0x15F then 0x05E; addr 0 reads 0x05E.
REQ-030 data=0x000, blink_mask=0x003 -> out_port alternates 0x000/0x003 every 4 cycles; addr 3 tracks out_port, addr 0 stays 0x000.
REQ-031 Write blink_mask=0 on the same edge as a phase toggle -> out_port equals data the next cycle, no residual toggle.
REQ-032 Assert reset_n low mid-blink with data=0x3FF -> out_port=0x000 immediately (RESET_VALUE=0); macro undefined build: write 0x3FF to addr 1 -> addr 1 reads 0, out_port unchanged.
